// File: rtl/sha2_round_const_seq.sv
// -----------------------------------------------------------------------------
// sha2_round_const_seq
// Round-constant sequencer for the SHA-2 compression core. It presents K[round]
// and the lookahead K[round+1] to the round datapath and steps through the
// 64 (SHA-224/256) or 80 (SHA-384/512) FIPS 180-4 constants. A start/advance
// handshake controls it, and it emits a one-cycle done pulse after the last
// round has been consumed.
//
// Ports
//   clk     in   1       rising-edge clock
//   rst     in   1       synchronous active-high reset
//   start   in   1       begin/restart a sequence (accepted in every state)
//   adv     in   1       advance one round (only honoured while running)
//   k       out  WORD_W  K[round]
//   k_next  out  WORD_W  K[round+1], K[0] on the final round
//   round   out  RND_W   current round index
//   valid   out  1       k/round valid (running)
//   last    out  1       valid on the final round
//   done    out  1       one-cycle pulse after the final round is consumed
// All outputs are registered.
// -----------------------------------------------------------------------------
module sha2_round_const_seq #(
  parameter int WORD_W = 32,
  parameter int RND_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              adv,
  output logic [WORD_W-1:0] k,
  output logic [WORD_W-1:0] k_next,
  output logic [RND_W-1:0]  round,
  output logic              valid,
  output logic              last,
  output logic              done
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("sha2_round_const_seq: WORD_W must be 32 or 64");
    end
    if (RND_W < 7) begin : g_bad_rnd
      $error("sha2_round_const_seq: RND_W must be at least 7");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The SHA-256 constants are exactly the upper 32 bits of the first 64
  // SHA-512 constants (both are fractional cube roots of the same primes),
  // so a single 80 x 64-bit table serves both widths.
  function automatic logic [63:0] k512(input logic [6:0] idx);
    logic [63:0] w;
    case (idx)
      7'd0:  w = 64'h428a2f98d728ae22;  7'd1:  w = 64'h7137449123ef65cd;
      7'd2:  w = 64'hb5c0fbcfec4d3b2f;  7'd3:  w = 64'he9b5dba58189dbbc;
      7'd4:  w = 64'h3956c25bf348b538;  7'd5:  w = 64'h59f111f1b605d019;
      7'd6:  w = 64'h923f82a4af194f9b;  7'd7:  w = 64'hab1c5ed5da6d8118;
      7'd8:  w = 64'hd807aa98a3030242;  7'd9:  w = 64'h12835b0145706fbe;
      7'd10: w = 64'h243185be4ee4b28c;  7'd11: w = 64'h550c7dc3d5ffb4e2;
      7'd12: w = 64'h72be5d74f27b896f;  7'd13: w = 64'h80deb1fe3b1696b1;
      7'd14: w = 64'h9bdc06a725c71235;  7'd15: w = 64'hc19bf174cf692694;
      7'd16: w = 64'he49b69c19ef14ad2;  7'd17: w = 64'hefbe4786384f25e3;
      7'd18: w = 64'h0fc19dc68b8cd5b5;  7'd19: w = 64'h240ca1cc77ac9c65;
      7'd20: w = 64'h2de92c6f592b0275;  7'd21: w = 64'h4a7484aa6ea6e483;
      7'd22: w = 64'h5cb0a9dcbd41fbd4;  7'd23: w = 64'h76f988da831153b5;
      7'd24: w = 64'h983e5152ee66dfab;  7'd25: w = 64'ha831c66d2db43210;
      7'd26: w = 64'hb00327c898fb213f;  7'd27: w = 64'hbf597fc7beef0ee4;
      7'd28: w = 64'hc6e00bf33da88fc2;  7'd29: w = 64'hd5a79147930aa725;
      7'd30: w = 64'h06ca6351e003826f;  7'd31: w = 64'h142929670a0e6e70;
      7'd32: w = 64'h27b70a8546d22ffc;  7'd33: w = 64'h2e1b21385c26c926;
      7'd34: w = 64'h4d2c6dfc5ac42aed;  7'd35: w = 64'h53380d139d95b3df;
      7'd36: w = 64'h650a73548baf63de;  7'd37: w = 64'h766a0abb3c77b2a8;
      7'd38: w = 64'h81c2c92e47edaee6;  7'd39: w = 64'h92722c851482353b;
      7'd40: w = 64'ha2bfe8a14cf10364;  7'd41: w = 64'ha81a664bbc423001;
      7'd42: w = 64'hc24b8b70d0f89791;  7'd43: w = 64'hc76c51a30654be30;
      7'd44: w = 64'hd192e819d6ef5218;  7'd45: w = 64'hd69906245565a910;
      7'd46: w = 64'hf40e35855771202a;  7'd47: w = 64'h106aa07032bbd1b8;
      7'd48: w = 64'h19a4c116b8d2d0c8;  7'd49: w = 64'h1e376c085141ab53;
      7'd50: w = 64'h2748774cdf8eeb99;  7'd51: w = 64'h34b0bcb5e19b48a8;
      7'd52: w = 64'h391c0cb3c5c95a63;  7'd53: w = 64'h4ed8aa4ae3418acb;
      7'd54: w = 64'h5b9cca4f7763e373;  7'd55: w = 64'h682e6ff3d6b2b8a3;
      7'd56: w = 64'h748f82ee5defb2fc;  7'd57: w = 64'h78a5636f43172f60;
      7'd58: w = 64'h84c87814a1f0ab72;  7'd59: w = 64'h8cc702081a6439ec;
      7'd60: w = 64'h90befffa23631e28;  7'd61: w = 64'ha4506cebde82bde9;
      7'd62: w = 64'hbef9a3f7b2c67915;  7'd63: w = 64'hc67178f2e372532b;
      7'd64: w = 64'hca273eceea26619c;  7'd65: w = 64'hd186b8c721c0c207;
      7'd66: w = 64'heada7dd6cde0eb1e;  7'd67: w = 64'hf57d4f7fee6ed178;
      7'd68: w = 64'h06f067aa72176fba;  7'd69: w = 64'h0a637dc5a2c898a6;
      7'd70: w = 64'h113f9804bef90dae;  7'd71: w = 64'h1b710b35131c471b;
      7'd72: w = 64'h28db77f523047d84;  7'd73: w = 64'h32caab7b40c72493;
      7'd74: w = 64'h3c9ebe0a15c9bebc;  7'd75: w = 64'h431d67c49c100d4c;
      7'd76: w = 64'h4cc5d4becb3e42b6;  7'd77: w = 64'h597f299cfc657e2a;
      7'd78: w = 64'h5fcb6fab3ad6faec;  7'd79: w = 64'h6c44198c4a475817;
      default: w = 64'h0000000000000000;
    endcase
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] krom(input logic [6:0] idx);
    logic [63:0] w;
    w = k512(idx);
    return w[63 -: WORD_W];
  endfunction

  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  state_e            state_q, state_d;
  logic [RND_W-1:0]  round_q, round_d;
  logic [WORD_W-1:0] k_q, k_d, k_next_q, k_next_d;
  logic              valid_q, valid_d, last_q, last_d, done_q, done_d;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      k_q      <= krom(7'd0);
      k_next_q <= krom(7'd1);
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      k_q      <= k_d;
      k_next_q <= k_next_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; start wins over adv in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (start)              state_d = ST_RUN;
        else if (adv && last_q) state_d = ST_DONE;
        else                    state_d = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  always_comb begin
    round_d = round_q;
    if (start) begin
      round_d = '0;
    end else if (state_q == ST_RUN && adv) begin
      // last_q marks the final round, so the wrap to 0 only happens via DONE.
      if (last_q) round_d = '0;
      else        round_d = round_q + RND_W'(1);
    end else begin
      round_d = round_q;
    end
    valid_d  = (state_d == ST_RUN);
    last_d   = (state_d == ST_RUN) && (round_d == RND_LAST);
    done_d   = (state_d == ST_DONE);
    k_d      = krom(7'(round_d));
    if (round_d == RND_LAST) k_next_d = krom(7'd0);
    else                     k_next_d = krom(7'(round_d + RND_W'(1)));
  end

  assign k      = k_q;
  assign k_next = k_next_q;
  assign round  = round_q;
  assign valid  = valid_q;
  assign last   = last_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sha2_round_const_seq.sv
// Bench for sha2_round_const_seq: one SHA-256 and one SHA-512 instance share
// the same stimulus. The reference constants are derived here from first
// principles (fractional cube roots of the first 80 primes) and the expected
// output of every cycle is queued for a negedge monitor.
module tb_sha2_round_const_seq;

  logic        clk;
  logic        rst, start, adv;
  logic [31:0] k32, kn32;
  logic [63:0] k64, kn64;
  logic [6:0]  rnd32, rnd64;
  logic        v32, l32, d32, v64, l64, d64;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] k;
    logic [63:0] kn;
    logic [6:0]  r;
    logic        v;
    logic        l;
    logic        d;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  logic [63:0] ktab[80];

  sha2_round_const_seq #(.WORD_W(32), .RND_W(7)) u32 (
    .clk(clk), .rst(rst), .start(start), .adv(adv),
    .k(k32), .k_next(kn32), .round(rnd32),
    .valid(v32), .last(l32), .done(d32)
  );

  sha2_round_const_seq #(.WORD_W(64), .RND_W(7)) u64 (
    .clk(clk), .rst(rst), .start(start), .adv(adv),
    .k(k64), .k_next(kn64), .round(rnd64),
    .valid(v64), .last(l64), .done(d64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // floor(frac(cbrt(p)) * 2^64), computed exactly with wide integers
  function automatic logic [63:0] cube_frac(input int p);
    logic [255:0] tgt, x, t;
    tgt = 256'(p) << 192;
    x   = '0;
    for (int b = 67; b >= 0; b--) begin
      t = x | (256'(1) << b);
      if (t * t * t <= tgt) x = t;
    end
    return x[63:0];
  endfunction

  function automatic logic [63:0] kval(input int w64, input int idx);
    logic [63:0] v;
    v = ktab[idx];
    if (w64 != 0) return v;
    return {32'h0, v[63:32]};
  endfunction

  // Reference model state: running flag, round index, done pulse per instance.
  bit m_run[2];
  int m_rnd[2];
  bit m_dn[2];

  function automatic exp_t model_step(input int d, input logic r, input logic s, input logic a);
    exp_t e;
    int nr;
    nr = (d != 0) ? 80 : 64;
    if (r) begin
      m_run[d] = 1'b0; m_rnd[d] = 0; m_dn[d] = 1'b0;
    end else if (s) begin
      m_run[d] = 1'b1; m_rnd[d] = 0; m_dn[d] = 1'b0;
    end else if (m_run[d] && a) begin
      if (m_rnd[d] == nr - 1) begin
        m_run[d] = 1'b0; m_rnd[d] = 0; m_dn[d] = 1'b1;
      end else begin
        m_rnd[d] = m_rnd[d] + 1; m_dn[d] = 1'b0;
      end
    end else begin
      m_dn[d] = 1'b0;
    end
    e.k  = kval(d, m_rnd[d]);
    e.kn = kval(d, (m_rnd[d] + 1) % nr);
    e.r  = 7'(m_rnd[d]);
    e.v  = m_run[d];
    e.l  = m_run[d] && (m_rnd[d] == nr - 1);
    e.d  = m_dn[d];
    return e;
  endfunction

  // Build the constant table, then predict each cycle's outputs at the edge.
  initial begin
    int n, cnt;
    bit prime;
    n = 2; cnt = 0;
    while (cnt < 80) begin
      prime = 1'b1;
      for (int j = 2; j * j <= n; j++) if (n % j == 0) prime = 1'b0;
      if (prime) begin
        ktab[cnt] = cube_frac(n);
        cnt++;
      end
      n++;
    end
    m_run = '{1'b0, 1'b0}; m_rnd = '{0, 0}; m_dn = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      q32.push_back(model_step(0, rst, start, adv));
      q64.push_back(model_step(1, rst, start, adv));
    end
  end

  task automatic cmp(input string name, input exp_t e, input exp_t a);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got k=%h kn=%h r=%0d v=%b l=%b d=%b want k=%h kn=%h r=%0d v=%b l=%b d=%b",
               name, $time, a.k, a.kn, a.r, a.v, a.l, a.d, e.k, e.kn, e.r, e.v, e.l, e.d);
    end
  endtask

  // Monitor: every cycle the DUTs present a registered output set.
  initial begin
    exp_t a;
    forever begin
      @(negedge clk);
      a = '{k: {32'h0, k32}, kn: {32'h0, kn32}, r: rnd32, v: v32, l: l32, d: d32};
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb32_empty t=%0t got no expectation", $time);
      end else cmp("sb32", q32.pop_front(), a);
      a = '{k: k64, kn: kn64, r: rnd64, v: v64, l: l64, d: d64};
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb64_empty t=%0t got no expectation", $time);
      end else cmp("sb64", q64.pop_front(), a);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic a, input logic r);
    start = s; adv = a; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; adv = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    chk("rst_valid", {63'h0, v32}, 64'h0);
    chk("rst_done",  {63'h0, d32}, 64'h0);
    chk("rst_round", {57'h0, rnd32}, 64'h0);
    chk("rst_k32",   {32'h0, k32}, 64'h00000000428a2f98);
    chk("rst_kn32",  {32'h0, kn32}, 64'h0000000071374491);
    chk("rst_k64",   k64, 64'h428a2f98d728ae22);
    chk("rst_kn64",  kn64, 64'h7137449123ef65cd);

    // Full run with adv held high.
    drive(1'b1, 1'b0, 1'b0);
    chk("start_valid", {63'h0, v32}, 64'h1);
    chk("start_k32",   {32'h0, k32}, 64'h00000000428a2f98);
    for (int i = 0; i < 63; i++) drive(1'b0, 1'b1, 1'b0);
    chk("r63_k32",   {32'h0, k32}, 64'h00000000c67178f2);
    chk("r63_last",  {63'h0, l32}, 64'h1);
    chk("r63_last64", {63'h0, l64}, 64'h0);
    drive(1'b0, 1'b1, 1'b0);
    chk("done32", {63'h0, d32}, 64'h1);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, 1'b0);
    chk("r79_k64",  k64, 64'h6c44198c4a475817);
    chk("r79_last", {63'h0, l64}, 64'h1);
    drive(1'b0, 1'b1, 1'b0);
    chk("done64", {63'h0, d64}, 64'h1);
    drive(1'b0, 1'b1, 1'b0);
    chk("idle64_done", {63'h0, d64}, 64'h0);

    // Stall at round 10.
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
    chk("stall_round", {57'h0, rnd32}, 64'd10);
    chk("stall_k32",   {32'h0, k32}, 64'h00000000243185be);
    drive(1'b0, 1'b1, 1'b0);
    chk("resume_round", {57'h0, rnd32}, 64'd11);

    // Restart at round 30 with adv also high.
    for (int i = 0; i < 19; i++) drive(1'b0, 1'b1, 1'b0);
    chk("pre_restart", {57'h0, rnd32}, 64'd30);
    drive(1'b1, 1'b1, 1'b0);
    chk("restart_round", {57'h0, rnd32}, 64'd0);
    chk("restart_done",  {63'h0, d32}, 64'h0);

    // Back-to-back: start during the DONE cycle.
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 1'b0);
    chk("b2b_done", {63'h0, d32}, 64'h1);
    drive(1'b1, 1'b0, 1'b0);
    chk("b2b_valid", {63'h0, v32}, 64'h1);
    chk("b2b_round", {57'h0, rnd32}, 64'd0);

    // Reset mid-run.
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    chk("midrst_valid", {63'h0, v64}, 64'h0);
    chk("midrst_k64",   k64, 64'h428a2f98d728ae22);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
